sub_serial_8bit: RTL
====================

SUB_SERIAL_8BIT -- requirements
Module: sub_serial_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new subtraction; sampled only while busy is low.
REQ-005 SHALL have ports x and y, input, WIDTH bits each: minuend and subtrahend, captured on an accepted start.
REQ-006 SHALL have port Bin, input, 1 bit: borrow-in, captured on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse marking D and Bout as valid.
REQ-009 SHALL have port D, output, WIDTH bits: difference x - y - Bin, modulo 2^WIDTH.
REQ-010 SHALL have port Bout, output, 1 bit: borrow-out, high when x < y + Bin (unsigned).

Function
REQ-011 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; acceptance latches x, y and Bin, clears the bit counter, and enters RUN.
REQ-013 SHALL ignore start while in RUN, with no effect on state, operands or outputs.
REQ-014 SHALL, in RUN, process one bit per cycle, LSB first, through the 1-bit full subtractor:
- d = x ^ y ^ b
- b' = (~x & y) | (~(x ^ y) & b)
REQ-015 SHALL write each difference bit into a shift register and feed the borrow back as b on the next cycle.
REQ-016 SHALL leave RUN for DONE after exactly WIDTH RUN cycles; the bit counter wraps from WIDTH-1 to DONE with no extra cycle.
REQ-017 SHALL give these latencies for start accepted at rising edge E0:
- busy high from E0 up to edge E0+WIDTH.
- D and Bout updated at edge E0+WIDTH.
- done high for exactly the one cycle after edge E0+WIDTH.
REQ-018 SHALL move from DONE to IDLE after one cycle, unless start is high, in which case the next operation is accepted back-to-back.
REQ-019 SHALL hold D and Bout stable from the done pulse until the next done pulse; intermediate shift contents SHALL NOT appear on D.
REQ-020 SHALL keep busy low in IDLE and DONE.

Reset
REQ-021 SHALL, while rst is high at a clock edge, force state IDLE, busy=0, done=0, D=0, Bout=0, the counter to 0 and the internal borrow to 0; ovf SHALL be 0 when present.
REQ-022 SHALL abort an in-flight operation on rst mid-RUN: no done pulse, and D/Bout read 0.
REQ-023 SHALL let reset take priority over a simultaneous start.

Configuration
REQ-024 SHALL, when macro SUB_SIGNED_OVF_EN is defined, add output port ovf (1 bit), registered and updated together with D.
- ovf = (x[MSB] != y[MSB]) && (D[MSB] != x[MSB]).
REQ-025 SHALL, when SUB_SIGNED_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-026 SHALL take the state enum (IDLE/RUN/DONE) and the default width constant from shared package sub_pkg.
REQ-027 SHALL instantiate exactly one sub-module, sub_comp_1bit (inputs x, y, Bin; outputs D, Bout), built from gate primitives, as the per-bit datapath.

Verification
REQ-028 SHALL pass: x=0x50, y=0x20, Bin=0 -> done 8 cycles after start, D=0x30, Bout=0, ovf=0.
REQ-029 SHALL pass: x=0x00, y=0x01, Bin=0 -> D=0xFF, Bout=1, ovf=0.
REQ-030 SHALL pass: x=0x80, y=0x01, Bin=0 -> D=0x7F, Bout=0, ovf=1 (macro defined).
REQ-031 SHALL pass: x=0x10, y=0x0F, Bin=1 -> D=0x00, Bout=0; then start again in the DONE cycle with x=0x05, y=0x07 -> D=0xFE, Bout=1, done exactly 9 cycles after the first done.
REQ-032 SHALL pass: start pulsed with x=0xAA, y=0x55 on the 3rd RUN cycle, and rst on the 5th RUN cycle -> no done pulse, busy=0, D=0x00, Bout=0 next cycle.
REQ-033 SHALL pass: random 1000 operands with Bin random -> D equals (x - y - Bin) mod 256 and Bout equals (x < y + Bin).

Source files
------------

// File: rtl/sub_pkg.sv
// Shared FSM state type and default operand width for the serial subtractor.
package sub_pkg;
    localparam int SUB_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;
endpackage

// File: rtl/sub_comp_1bit.sv
// Gate-level 1-bit full subtractor: D = x ^ y ^ Bin, Bout = (~x & y) | (~(x ^ y) & Bin).
module sub_comp_1bit (
    input  logic x,
    input  logic y,
    input  logic Bin,
    output wire  D,
    output wire  Bout
);
    wire xy_x;
    wire x_n;
    wire xy_xn;
    wire t_a;
    wire t_b;

    xor g_xy   (xy_x, x, y);
    xor g_d    (D, xy_x, Bin);
    not g_xn   (x_n, x);
    not g_xyn  (xy_xn, xy_x);
    and g_ta   (t_a, x_n, y);
    and g_tb   (t_b, xy_xn, Bin);
    or  g_bout (Bout, t_a, t_b);
endmodule

// File: rtl/sub_serial_8bit.sv
// Bit-serial D = x - y - Bin, LSB first; result and done appear WIDTH cycles after an accepted start.
// start is ignored while busy. Define SUB_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module sub_serial_8bit
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic [WIDTH-2:0] sh_q;
    logic             b_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             bit_d, bit_b;
    logic             accept, last;

    assign accept = start && (state_q != RUN);
    assign last   = (cnt_q == CW'(WIDTH - 1));

    sub_comp_1bit u_cell (
        .x    (x_q[0]),
        .y    (y_q[0]),
        .Bin  (b_q),
        .D    (bit_d),
        .Bout (bit_b)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Partial difference bits stay in sh_q; D only changes on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            sh_q   <= '0;
            b_q    <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            x_q   <= x;
            y_q   <= y;
            b_q   <= Bin;
        end else if (state_q == RUN) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            x_q   <= {1'b0, x_q[WIDTH-1:1]};
            y_q   <= {1'b0, y_q[WIDTH-1:1]};
            b_q   <= bit_b;
            sh_q  <= {bit_d, sh_q[WIDTH-2:1]};
            if (last) begin
                d_q    <= {bit_d, sh_q};
                bout_q <= bit_b;
            end
        end
    end

    assign D    = d_q;
    assign Bout = bout_q;

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_q;

    // On the last RUN cycle x_q[0]/y_q[0] hold the operand sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!accept && (state_q == RUN) && last) begin
            ovf_q <= (x_q[0] != y_q[0]) && (bit_d != x_q[0]);
        end
    end

    assign ovf = ovf_q;
`endif
endmodule
